// File: rtl/uart_tx_feeder.sv
// uart_tx_feeder: FIFO-buffered byte launcher feeding the UART TX with one-cycle data-valid pulses
// Ports: clk_i/rst_i (async active-high); in_data_i/in_valid_i/in_ready_o system-side write handshake;
// tx_busy_i from UART TX; tx_p_data_o/tx_data_valid_o launch to TX; fifo_count_o/fifo_empty_o/fifo_full_o
// FIFO status; handshake_err_o sticky flag for a launch the TX never acknowledged.
module uart_tx_feeder #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 8,
  localparam int ADDR_WIDTH = $clog2(FIFO_DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [DATA_WIDTH-1:0] in_data_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic                  tx_busy_i,
  output logic [DATA_WIDTH-1:0] tx_p_data_o,
  output logic                  tx_data_valid_o,
  output logic [ADDR_WIDTH:0]   fifo_count_o,
  output logic                  fifo_empty_o,
  output logic                  fifo_full_o,
  output logic                  handshake_err_o
);
  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE} state_t;
  state_t                  state_q, state_d;
  logic [1:0]              guard_q, guard_d;
  logic                    err_q, err_d;
  logic                    valid_q;
  logic [DATA_WIDTH-1:0]   data_q;
  logic [DATA_WIDTH-1:0]   mem_q [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0]   wr_ptr_q, rd_ptr_q;
  logic [ADDR_WIDTH:0]     count_q, count_d;
  logic                    wr_en, pop;
  assign fifo_count_o    = count_q;
  assign fifo_empty_o    = count_q == '0;
  assign fifo_full_o     = count_q == (ADDR_WIDTH+1)'(FIFO_DEPTH);
  assign in_ready_o      = !fifo_full_o;
  assign tx_p_data_o     = data_q;
  assign tx_data_valid_o = valid_q;
  assign handshake_err_o = err_q;
  assign wr_en = in_valid_i && in_ready_o;
  assign pop   = (state_q == IDLE) && !fifo_empty_o && !tx_busy_i;
  assign count_d = count_q + (ADDR_WIDTH+1)'(wr_en) - (ADDR_WIDTH+1)'(pop);
  always_comb begin
    state_d = state_q;
    guard_d = guard_q;
    err_d   = err_q;
    case (state_q)
      IDLE:      state_d = pop ? LAUNCH : IDLE;
      LAUNCH: begin
        state_d = WAIT_BUSY;
        guard_d = '0;
      end
      WAIT_BUSY: begin
        if (tx_busy_i) state_d = WAIT_DONE;
        else if (guard_q == 2'd2) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else guard_d = guard_q + 2'd1;
      end
      WAIT_DONE: state_d = tx_busy_i ? WAIT_DONE : IDLE;
      default:   state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      guard_q  <= '0;
      err_q    <= 1'b0;
      valid_q  <= 1'b0;
      data_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      guard_q  <= guard_d;
      err_q    <= err_d;
      valid_q  <= state_d == LAUNCH;
      count_q  <= count_d;
      if (wr_en) wr_ptr_q <= wr_ptr_q + ADDR_WIDTH'(1);
      if (pop) begin
        data_q   <= mem_q[rd_ptr_q];
        rd_ptr_q <= rd_ptr_q + ADDR_WIDTH'(1);
      end
    end
  end
  always_ff @(posedge clk_i) begin
    if (wr_en) mem_q[wr_ptr_q] <= in_data_i;
  end
endmodule

// File: tb/tb_uart_tx_feeder.sv
// tb_uart_tx_feeder: directed self-checking bench for uart_tx_feeder with a cycle-stepped TX busy model
module tb_uart_tx_feeder;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] in_data = '0;
  logic       in_valid = 1'b0;
  logic       tx_busy = 1'b0;
  logic       in_ready, tx_data_valid, fifo_empty, fifo_full, handshake_err;
  logic [7:0] tx_p_data;
  logic [3:0] fifo_count;
  int         checks = 0, failures = 0;
  logic [7:0] log_q [$];
  bit         force_busy = 1'b0, ack_en = 1'b0;
  int         frame_len = 3, bcnt = 0, dbl = 0, busy_launch = 0;
  uart_tx_feeder dut (
    .clk_i(clk), .rst_i(rst), .in_data_i(in_data), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .tx_busy_i(tx_busy), .tx_p_data_o(tx_p_data), .tx_data_valid_o(tx_data_valid),
    .fifo_count_o(fifo_count), .fifo_empty_o(fifo_empty), .fifo_full_o(fifo_full),
    .handshake_err_o(handshake_err)
  );
  always #5 clk = ~clk;
  task automatic tick();
    bit pv;
    pv = tx_data_valid;
    @(posedge clk);
    #1;
    if (tx_data_valid) begin
      log_q.push_back(tx_p_data);
      if (pv) dbl++;
      if (tx_busy) busy_launch++;
    end
    if (force_busy) tx_busy = 1'b1;
    else if (ack_en && pv) begin
      tx_busy = 1'b1;
      bcnt = frame_len;
    end else if (bcnt > 0) begin
      bcnt--;
      if (bcnt == 0) tx_busy = 1'b0;
    end else tx_busy = 1'b0;
  endtask
  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (tx_data_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", tx_data_valid); end
    checks++; if (tx_p_data !== 8'h00) begin failures++; $display("FAIL reset_data got=%h exp=00", tx_p_data); end
    checks++; if (fifo_count !== 4'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", fifo_count); end
    checks++; if (fifo_empty !== 1'b1) begin failures++; $display("FAIL reset_empty got=%b exp=1", fifo_empty); end
    checks++; if (fifo_full !== 1'b0) begin failures++; $display("FAIL reset_full got=%b exp=0", fifo_full); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", in_ready); end
    checks++; if (handshake_err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", handshake_err); end
    rst = 1'b0;
  endtask
  task automatic test_single();
    log_q.delete();
    ack_en = 1'b1;
    frame_len = 4;
    in_data = 8'hA5;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    checks++; if (fifo_count !== 4'd1) begin failures++; $display("FAIL single_count_after_write got=%0d exp=1", fifo_count); end
    checks++; if (tx_data_valid !== 1'b0) begin failures++; $display("FAIL single_valid_early got=%b exp=0", tx_data_valid); end
    tick();
    checks++; if (tx_data_valid !== 1'b1) begin failures++; $display("FAIL single_valid got=%b exp=1", tx_data_valid); end
    checks++; if (tx_p_data !== 8'hA5) begin failures++; $display("FAIL single_data got=%h exp=a5", tx_p_data); end
    checks++; if (fifo_count !== 4'd0) begin failures++; $display("FAIL single_count_after_pop got=%0d exp=0", fifo_count); end
    checks++; if (fifo_empty !== 1'b1) begin failures++; $display("FAIL single_empty got=%b exp=1", fifo_empty); end
    tick();
    checks++; if (tx_data_valid !== 1'b0) begin failures++; $display("FAIL single_valid_width got=%b exp=0", tx_data_valid); end
    for (int i = 0; i < 20 && tx_busy; i++) begin
      checks++; if (tx_p_data !== 8'hA5) begin failures++; $display("FAIL single_hold got=%h exp=a5", tx_p_data); end
      tick();
    end
    repeat (3) tick();
    checks++; if (log_q.size() != 1 || log_q[0] !== 8'hA5) begin failures++; $display("FAIL single_launches got=%0d exp=1", log_q.size()); end
  endtask
  task automatic test_burst();
    log_q.delete();
    ack_en = 1'b0;
    force_busy = 1'b1;
    tx_busy = 1'b1;
    tick();
    for (int i = 1; i <= 9; i++) begin
      in_data = 8'(i);
      in_valid = 1'b1;
      if (i == 9) begin
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL burst_ready_at_9 got=%b exp=0", in_ready); end
      end
      tick();
    end
    in_valid = 1'b0;
    checks++; if (fifo_count !== 4'd8) begin failures++; $display("FAIL burst_count got=%0d exp=8", fifo_count); end
    checks++; if (fifo_full !== 1'b1) begin failures++; $display("FAIL burst_full got=%b exp=1", fifo_full); end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL burst_ready got=%b exp=0", in_ready); end
    checks++; if (log_q.size() != 0) begin failures++; $display("FAIL burst_launch_while_busy got=%0d exp=0", log_q.size()); end
    force_busy = 1'b0;
    tx_busy = 1'b0;
    ack_en = 1'b1;
    frame_len = 3;
    for (int i = 0; i < 300 && log_q.size() < 8; i++) tick();
    repeat (10) tick();
    checks++; if (log_q.size() != 8) begin failures++; $display("FAIL burst_launches got=%0d exp=8", log_q.size()); end
    for (int i = 0; i < 8 && i < log_q.size(); i++) begin
      checks++; if (log_q[i] !== 8'(i + 1)) begin failures++; $display("FAIL burst_order[%0d] got=%h exp=%h", i, log_q[i], 8'(i + 1)); end
    end
    checks++; if (busy_launch != 0) begin failures++; $display("FAIL burst_launch_during_busy got=%0d exp=0", busy_launch); end
    checks++; if (fifo_empty !== 1'b1) begin failures++; $display("FAIL burst_drained got=%b exp=1", fifo_empty); end
  endtask
  task automatic test_simultaneous();
    logic [7:0] exp_b [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    log_q.delete();
    ack_en = 1'b0;
    force_busy = 1'b1;
    tx_busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = exp_b[i];
      in_valid = 1'b1;
      tick();
    end
    checks++; if (fifo_count !== 4'd3) begin failures++; $display("FAIL simul_pre_count got=%0d exp=3", fifo_count); end
    in_data = 8'h44;
    force_busy = 1'b0;
    tx_busy = 1'b0;
    ack_en = 1'b1;
    frame_len = 3;
    tick();
    in_valid = 1'b0;
    checks++; if (fifo_count !== 4'd3) begin failures++; $display("FAIL simul_count got=%0d exp=3", fifo_count); end
    checks++; if (tx_data_valid !== 1'b1) begin failures++; $display("FAIL simul_valid got=%b exp=1", tx_data_valid); end
    checks++; if (tx_p_data !== 8'h11) begin failures++; $display("FAIL simul_data got=%h exp=11", tx_p_data); end
    for (int i = 0; i < 200 && log_q.size() < 4; i++) tick();
    repeat (8) tick();
    checks++; if (log_q.size() != 4) begin failures++; $display("FAIL simul_launches got=%0d exp=4", log_q.size()); end
    for (int i = 0; i < 4 && i < log_q.size(); i++) begin
      checks++; if (log_q[i] !== exp_b[i]) begin failures++; $display("FAIL simul_order[%0d] got=%h exp=%h", i, log_q[i], exp_b[i]); end
    end
  endtask
  task automatic test_no_ack();
    log_q.delete();
    ack_en = 1'b0;
    checks++; if (handshake_err !== 1'b0) begin failures++; $display("FAIL noack_pre_err got=%b exp=0", handshake_err); end
    in_data = 8'h3C;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    checks++; if (tx_data_valid !== 1'b1 || tx_p_data !== 8'h3C) begin failures++; $display("FAIL noack_launch got=%b/%h exp=1/3c", tx_data_valid, tx_p_data); end
    repeat (3) tick();
    checks++; if (handshake_err !== 1'b0) begin failures++; $display("FAIL noack_err_early got=%b exp=0", handshake_err); end
    tick();
    checks++; if (handshake_err !== 1'b1) begin failures++; $display("FAIL noack_err got=%b exp=1", handshake_err); end
    ack_en = 1'b1;
    in_data = 8'h5A;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    checks++; if (tx_data_valid !== 1'b0) begin failures++; $display("FAIL noack_next_early got=%b exp=0", tx_data_valid); end
    tick();
    checks++; if (tx_data_valid !== 1'b1 || tx_p_data !== 8'h5A) begin failures++; $display("FAIL noack_next_launch got=%b/%h exp=1/5a", tx_data_valid, tx_p_data); end
    repeat (10) tick();
    checks++; if (handshake_err !== 1'b1) begin failures++; $display("FAIL noack_sticky got=%b exp=1", handshake_err); end
  endtask
  task automatic test_wrap();
    int idx = 0, cnt_m = 0;
    bit rdy;
    log_q.delete();
    ack_en = 1'b1;
    frame_len = 2;
    for (int g = 0; g < 3000 && log_q.size() < 20; g++) begin
      in_valid = idx < 20;
      in_data = 8'(8'h40 + idx);
      rdy = in_ready;
      tick();
      if (in_valid && rdy) begin
        idx++;
        cnt_m++;
      end
      if (tx_data_valid) cnt_m--;
      checks++; if (fifo_count !== 4'(cnt_m)) begin failures++; $display("FAIL wrap_count got=%0d exp=%0d", fifo_count, cnt_m); end
    end
    in_valid = 1'b0;
    repeat (8) tick();
    checks++; if (log_q.size() != 20) begin failures++; $display("FAIL wrap_launches got=%0d exp=20", log_q.size()); end
    for (int i = 0; i < 20 && i < log_q.size(); i++) begin
      checks++; if (log_q[i] !== 8'(8'h40 + i)) begin failures++; $display("FAIL wrap_order[%0d] got=%h exp=%h", i, log_q[i], 8'(8'h40 + i)); end
    end
    checks++; if (fifo_empty !== 1'b1) begin failures++; $display("FAIL wrap_empty got=%b exp=1", fifo_empty); end
  endtask
  task automatic test_reset_mid();
    log_q.delete();
    ack_en = 1'b0;
    force_busy = 1'b1;
    tx_busy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_data = 8'(8'h90 + i);
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    force_busy = 1'b0;
    tx_busy = 1'b0;
    ack_en = 1'b1;
    frame_len = 10;
    repeat (4) tick();
    checks++; if (fifo_count !== 4'd4) begin failures++; $display("FAIL rstmid_pre_count got=%0d exp=4", fifo_count); end
    rst = 1'b1;
    #1;
    checks++; if (fifo_count !== 4'd0) begin failures++; $display("FAIL rstmid_count got=%0d exp=0", fifo_count); end
    checks++; if (fifo_empty !== 1'b1) begin failures++; $display("FAIL rstmid_empty got=%b exp=1", fifo_empty); end
    checks++; if (tx_data_valid !== 1'b0 || tx_p_data !== 8'h00) begin failures++; $display("FAIL rstmid_tx got=%b/%h exp=0/00", tx_data_valid, tx_p_data); end
    checks++; if (handshake_err !== 1'b0) begin failures++; $display("FAIL rstmid_err got=%b exp=0", handshake_err); end
    checks++; if (in_ready !== 1'b1 || fifo_full !== 1'b0) begin failures++; $display("FAIL rstmid_ready got=%b/%b exp=1/0", in_ready, fifo_full); end
    #3;
    rst = 1'b0;
    tx_busy = 1'b0;
    bcnt = 0;
    log_q.delete();
    repeat (10) tick();
    checks++; if (log_q.size() != 0) begin failures++; $display("FAIL rstmid_spurious got=%0d exp=0", log_q.size()); end
    checks++; if (fifo_count !== 4'd0) begin failures++; $display("FAIL rstmid_post_count got=%0d exp=0", fifo_count); end
    in_data = 8'h77;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    checks++; if (tx_data_valid !== 1'b1 || tx_p_data !== 8'h77) begin failures++; $display("FAIL rstmid_new got=%b/%h exp=1/77", tx_data_valid, tx_p_data); end
    repeat (15) tick();
  endtask
  initial begin
    test_reset();
    test_single();
    test_burst();
    test_simultaneous();
    test_no_ack();
    test_wrap();
    test_reset_mid();
    checks++; if (dbl != 0) begin failures++; $display("FAIL valid_pulse_width got=%0d exp=0", dbl); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/uart_tx_feeder.md
# uart_tx_feeder

Upstream buffering stage for the UART transmit path. Accepts bytes from the system side over a valid/ready handshake, stores them in a small FIFO, and launches them one at a time into the UART TX (its FSM and serializer) with a one-cycle data-valid pulse. The pulse and data are gated by the TX busy flag, so no byte is issued while a frame is in flight. A sticky error flags a TX that never acknowledges a launch.

## Interface
- DATA_WIDTH, 8, width of one UART data word
- FIFO_DEPTH, 8, buffer entries; power of two, at least 2
- ADDR_WIDTH, log2(FIFO_DEPTH), pointer width (derived, not overridden)

- CLK  in  1  single clock for the whole block
- RST  in  1  reset, asynchronous, active-high
- IN_DATA  in  DATA_WIDTH  byte from system side
- IN_VALID  in  1  IN_DATA valid
- IN_READY  out  1  FIFO can accept; combinational, equal to !FIFO_FULL
- TX_BUSY  in  1  busy flag from UART TX; registered there, rises one cycle after a launch pulse
- TX_P_DATA  out  DATA_WIDTH  parallel byte to TX serializer; registered
- TX_DATA_VALID  out  1  launch pulse to TX FSM; exactly one cycle wide, registered
- FIFO_COUNT  out  ADDR_WIDTH+1  entries stored, 0..FIFO_DEPTH
- FIFO_EMPTY  out  1  FIFO_COUNT == 0
- FIFO_FULL  out  1  FIFO_COUNT == FIFO_DEPTH
- HANDSHAKE_ERR  out  1  sticky; TX failed to raise TX_BUSY after a launch

## Operation
- **Write:** occurs on the edge where IN_VALID && IN_READY. The byte is stored at the write pointer, and the pointer advances modulo FIFO_DEPTH (natural wrap).
- **Full FIFO:** IN_READY is low and IN_DATA is ignored, even if a pop happens on the same edge. There is no write-through and no same-cycle slot reuse.
- **Launch FSM states:** IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE.
  - **IDLE:** if !FIFO_EMPTY && !TX_BUSY, go to LAUNCH. On that edge, pop the head into TX_P_DATA, advance the read pointer and decrement the count. Otherwise stay.
  - **LAUNCH:** TX_DATA_VALID = 1 for this one cycle. Unconditionally go to WAIT_BUSY.
  - **WAIT_BUSY:** a 2-bit guard counter starts at 0.
    - If TX_BUSY = 1, go to WAIT_DONE.
    - Else if the guard reaches 2 (third cycle without busy), set HANDSHAKE_ERR and go to IDLE.
    - Otherwise increment the guard.
  - **WAIT_DONE:** when TX_BUSY = 0, go to IDLE.
- TX_DATA_VALID is driven only in LAUNCH; it is never high in any other state.
- TX_P_DATA holds its value from the pop edge until the next pop. It is stable for the whole frame.
- **Simultaneous write and pop:** both happen and the count is unchanged. Pointers update independently.
- **Counter width:** FIFO_COUNT uses ADDR_WIDTH+1 bits. Full is detected by count, not by pointer equality.
- **HANDSHAKE_ERR:** cleared only by RST. After an error the FSM keeps servicing the FIFO; the popped byte is considered lost.
- **Reset mid-operation:** the FIFO is emptied, buffered bytes are discarded, the FSM returns to IDLE, and any in-flight TX frame is not tracked.

## Timing
- **Reset values:** TX_DATA_VALID 0, TX_P_DATA 0, FIFO_COUNT 0, FIFO_EMPTY 1, FIFO_FULL 0, IN_READY 1, HANDSHAKE_ERR 0, FSM IDLE, pointers 0.
- **Latency:** a byte written on edge E0 into an empty FIFO, with TX idle, is popped on E1. TX_DATA_VALID is high from E1 to E2, and TX_BUSY is expected high from E2.
- **Back-to-back:** after TX_BUSY falls at edge Ek, the FSM returns to IDLE at Ek+1. The next pop happens at Ek+2 at the earliest, so there is at least one idle cycle between frames.
- **Throughput:** one byte per TX frame. The FIFO absorbs bursts of up to FIFO_DEPTH bytes.
- **Flag timing:** FIFO_COUNT and the flags update on the same edge as the write or pop. IN_READY follows FIFO_FULL combinationally within the same cycle.
- **Error timing:** HANDSHAKE_ERR rises on the edge that ends the third consecutive WAIT_BUSY cycle with TX_BUSY = 0.

## Test plan
- **Single byte:** after reset, write 0xA5 with TX model idle. Expect TX_DATA_VALID high for exactly 1 cycle, one cycle after the write edge, and TX_P_DATA = 0xA5 held until the model drops busy. FIFO_COUNT returns 1 -> 0.
- **Burst to full:** hold TX_BUSY = 1 and write 9 bytes 0x01..0x09 with IN_VALID constant. Expect IN_READY low after 8 bytes, FIFO_FULL = 1, and 0x09 not accepted. Then release busy. Expect output order 0x01..0x08 with one launch per busy low period.
- **Simultaneous write and pop:** FIFO_COUNT = 3, TX idle, write on the pop edge. Expect FIFO_COUNT stays 3 and the next launched byte is the oldest entry.
- **No acknowledge:** TX model never raises busy after a launch of 0x3C. Expect HANDSHAKE_ERR = 1 three cycles after LAUNCH and the FSM back in IDLE. The next byte still launches.
- **Pointer wrap:** write and drain 20 bytes with a counting pattern through depth 8. Expect in-order delivery and no count corruption at pointer wrap.
- **Reset mid-operation:** with 4 bytes queued, assert RST during WAIT_DONE. Expect all outputs at reset values immediately, FIFO_EMPTY = 1, and no TX_DATA_VALID after release until a new write.
